// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the result producers, the UART TX serializer
// and the arbiter that shares the serializer between them.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   TXArb_RF_Data;
  logic                    TXArb_RF_Valid;
  logic [2*DATA_WIDTH-1:0] TXArb_ALU_Out;
  logic                    TXArb_ALU_Valid;
  logic                    TXArb_Busy;
  logic [DATA_WIDTH-1:0]   TXArb_TXPdata_Out;
  logic                    TXArb_Data_Valid;
  logic                    TXArb_RF_Pending;
  logic                    TXArb_ALU_Pending;
  logic                    TXArb_Overrun;
  logic                    TXArb_Timeout;
  logic                    TXArb_Idle;

  modport master (
    output TXArb_RF_Data, TXArb_RF_Valid, TXArb_ALU_Out, TXArb_ALU_Valid, TXArb_Busy,
    input  TXArb_TXPdata_Out, TXArb_Data_Valid, TXArb_RF_Pending, TXArb_ALU_Pending,
           TXArb_Overrun, TXArb_Timeout, TXArb_Idle
  );

  modport slave (
    input  TXArb_RF_Data, TXArb_RF_Valid, TXArb_ALU_Out, TXArb_ALU_Valid, TXArb_Busy,
    output TXArb_TXPdata_Out, TXArb_Data_Valid, TXArb_RF_Pending, TXArb_ALU_Pending,
           TXArb_Overrun, TXArb_Timeout, TXArb_Idle
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART TX serializer from an 8-bit register-file
// source and a 16-bit ALU source (LS byte first), with overrun and timeout flags.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic              TXArb_CLK,
  input  logic              TXArb_RST,
  uart_tx_arbiter_if.slave  bus
);

  localparam int WORD_WIDTH = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_LO = 3'd1,
    WAIT_LO = 3'd2,
    SEND_HI = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rf_buf_q, rf_buf_d;
  logic [WORD_WIDTH-1:0]   alu_buf_q, alu_buf_d;
  logic                    rf_pend_q, rf_pend_d;
  logic                    alu_pend_q, alu_pend_d;
  logic                    last_grant_q, last_grant_d;
  logic                    cur_alu_q, cur_alu_d;
  logic [WORD_WIDTH-1:0]   word_q, word_d;
  logic [DATA_WIDTH-1:0]   txp_q, txp_d;
  logic                    dv_q, dv_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    grant_rf;
  logic                    grant_alu;
  logic [WORD_WIDTH-1:0]   sel_word;

  always_comb begin
    state_d      = state_q;
    rf_buf_d     = rf_buf_q;
    alu_buf_d    = alu_buf_q;
    rf_pend_d    = rf_pend_q;
    alu_pend_d   = alu_pend_q;
    last_grant_d = last_grant_q;
    cur_alu_d    = cur_alu_q;
    word_d       = word_q;
    txp_d        = txp_q;
    dv_d         = dv_q;
    overrun_d    = 1'b0;
    timeout_d    = 1'b0;
    cnt_d        = cnt_q;
    grant_rf     = 1'b0;
    grant_alu    = 1'b0;
    sel_word     = '0;

    case (state_q)
      IDLE: begin
        if (!bus.TXArb_Busy && (rf_pend_q || alu_pend_q)) begin
          // last_grant_q==1 means ALU went last, so RF wins a tie
          if (rf_pend_q && (!alu_pend_q || last_grant_q)) begin
            grant_rf = 1'b1;
            sel_word = {{DATA_WIDTH{1'b0}}, rf_buf_q};
          end else begin
            grant_alu = 1'b1;
            sel_word  = alu_buf_q;
          end
          last_grant_d = grant_alu;
          cur_alu_d    = grant_alu;
          word_d       = sel_word;
          txp_d        = sel_word[DATA_WIDTH-1:0];
          dv_d         = 1'b1;
          cnt_d        = '0;
          state_d      = SEND_LO;
        end
      end

      SEND_LO, SEND_HI: begin
        if (bus.TXArb_Busy) begin
          dv_d    = 1'b0;
          cnt_d   = '0;
          state_d = (state_q == SEND_LO) ? WAIT_LO : WAIT_HI;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          dv_d      = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_LO: begin
        if (!bus.TXArb_Busy) begin
          if (cur_alu_q) begin
            txp_d   = word_q[WORD_WIDTH-1:DATA_WIDTH];
            dv_d    = 1'b1;
            cnt_d   = '0;
            state_d = SEND_HI;
          end else begin
            state_d = IDLE;
          end
        end
      end

      WAIT_HI: begin
        if (!bus.TXArb_Busy) begin
          state_d = IDLE;
        end
      end

      default: begin
        dv_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A grant frees the buffer at the same edge, so a simultaneous capture is accepted
    if (grant_rf) begin
      rf_pend_d = 1'b0;
    end
    if (bus.TXArb_RF_Valid) begin
      if (rf_pend_q && !grant_rf) begin
        overrun_d = 1'b1;
      end else begin
        rf_buf_d  = bus.TXArb_RF_Data;
        rf_pend_d = 1'b1;
      end
    end

    if (grant_alu) begin
      alu_pend_d = 1'b0;
    end
    if (bus.TXArb_ALU_Valid) begin
      if (alu_pend_q && !grant_alu) begin
        overrun_d = 1'b1;
      end else begin
        alu_buf_d  = bus.TXArb_ALU_Out;
        alu_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge TXArb_CLK or posedge TXArb_RST) begin
    if (TXArb_RST) begin
      state_q      <= IDLE;
      rf_buf_q     <= '0;
      alu_buf_q    <= '0;
      rf_pend_q    <= 1'b0;
      alu_pend_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cur_alu_q    <= 1'b0;
      word_q       <= '0;
      txp_q        <= '0;
      dv_q         <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rf_buf_q     <= rf_buf_d;
      alu_buf_q    <= alu_buf_d;
      rf_pend_q    <= rf_pend_d;
      alu_pend_q   <= alu_pend_d;
      last_grant_q <= last_grant_d;
      cur_alu_q    <= cur_alu_d;
      word_q       <= word_d;
      txp_q        <= txp_d;
      dv_q         <= dv_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.TXArb_TXPdata_Out = txp_q;
  assign bus.TXArb_Data_Valid  = dv_q;
  assign bus.TXArb_RF_Pending  = rf_pend_q;
  assign bus.TXArb_ALU_Pending = alu_pend_q;
  assign bus.TXArb_Overrun     = overrun_q;
  assign bus.TXArb_Timeout     = timeout_q;
  assign bus.TXArb_Idle        = (state_q == IDLE) && !rf_pend_q && !alu_pend_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: a small serializer model answers each
// Data_Valid with a 10-cycle Busy frame and logs the bytes it accepted.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_arbiter #(
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(8),
    .CNT_WIDTH     (4)
  ) dut (
    .TXArb_CLK(clk),
    .TXArb_RST(rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       model_en   = 1'b0;
  logic       busy_force = 1'b0;
  logic       model_busy = 1'b0;
  int         model_cnt  = 0;
  logic [7:0] sent_q[$];

  assign bus.TXArb_Busy = model_en ? model_busy : busy_force;

  // Serializer model: sees Data_Valid shortly after the edge, raises Busy for 10 cycles
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst || !model_en) begin
        model_busy = 1'b0;
        model_cnt  = 0;
      end else if (model_cnt > 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) model_busy = 1'b0;
      end else if (bus.TXArb_Data_Valid) begin
        model_busy = 1'b1;
        model_cnt  = 10;
        sent_q.push_back(bus.TXArb_TXPdata_Out);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_rf(input logic [7:0] d);
    bus.TXArb_RF_Data  = d;
    bus.TXArb_RF_Valid = 1'b1;
    tick();
    bus.TXArb_RF_Valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] d);
    bus.TXArb_ALU_Out   = d;
    bus.TXArb_ALU_Valid = 1'b1;
    tick();
    bus.TXArb_ALU_Valid = 1'b0;
  endtask

  task automatic pulse_both(input logic [7:0] r, input logic [15:0] a);
    bus.TXArb_RF_Data   = r;
    bus.TXArb_ALU_Out   = a;
    bus.TXArb_RF_Valid  = 1'b1;
    bus.TXArb_ALU_Valid = 1'b1;
    tick();
    bus.TXArb_RF_Valid  = 1'b0;
    bus.TXArb_ALU_Valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.TXArb_Idle && !bus.TXArb_Busy && !bus.TXArb_Data_Valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    bit found;
    #1 rst = 1'b1;
    tick();
    checks++;
    if (bus.TXArb_Data_Valid !== 1'b0 || bus.TXArb_TXPdata_Out !== 8'h00 || bus.TXArb_Idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_initial: dv=%b txp=%h idle=%b, required dv=0 txp=00 idle=1",
               bus.TXArb_Data_Valid, bus.TXArb_TXPdata_Out, bus.TXArb_Idle);
    end
    rst = 1'b0;
    model_en = 1'b1;
    tick();
    pulse_alu(16'h1234);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.TXArb_Data_Valid && bus.TXArb_TXPdata_Out == 8'h12) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL reset_reach_send_hi: MS byte 12 never presented, required it within 100 cycles");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.TXArb_Data_Valid !== 1'b0 || bus.TXArb_TXPdata_Out !== 8'h00 || bus.TXArb_Idle !== 1'b1 ||
        bus.TXArb_RF_Pending !== 1'b0 || bus.TXArb_ALU_Pending !== 1'b0 ||
        bus.TXArb_Overrun !== 1'b0 || bus.TXArb_Timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_send_hi: dv=%b txp=%h idle=%b rfp=%b alup=%b ovr=%b to=%b, required 0,00,1,0,0,0,0",
               bus.TXArb_Data_Valid, bus.TXArb_TXPdata_Out, bus.TXArb_Idle, bus.TXArb_RF_Pending,
               bus.TXArb_ALU_Pending, bus.TXArb_Overrun, bus.TXArb_Timeout);
    end
    tick();
    tick();
    rst = 1'b0;
    sent_q.delete();
    tick();
    pulse_rf(8'h3C);
    checks++;
    if (bus.TXArb_RF_Pending !== 1'b1 || bus.TXArb_Data_Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rf_capture_latency: rfp=%b dv=%b, required rfp=1 dv=0",
               bus.TXArb_RF_Pending, bus.TXArb_Data_Valid);
    end
    tick();
    checks++;
    if (bus.TXArb_Data_Valid !== 1'b1 || bus.TXArb_TXPdata_Out !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL rf_send_latency: dv=%b txp=%h, required dv=1 txp=3c",
               bus.TXArb_Data_Valid, bus.TXArb_TXPdata_Out);
    end
    wait_idle(ok);
    checks++;
    if (!ok || sent_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL rf_after_reset_done: idle_reached=%b bytes=%0d, required 1 and 1", ok, sent_q.size());
    end
  endtask

  task automatic test_alu_16bit();
    int dv_cycles = 0;
    bit ok = 1'b0;
    sent_q.delete();
    pulse_alu(16'hBEEF);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.TXArb_Data_Valid) dv_cycles++;
      if (bus.TXArb_Idle && !bus.TXArb_Busy && !bus.TXArb_Data_Valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || sent_q.size() != 2 || sent_q[0] !== 8'hEF || sent_q[1] !== 8'hBE) begin
      errors++;
      $display("[TB] FAIL alu_bytes: idle=%b count=%0d first=%h second=%h, required 1,2,ef,be",
               ok, sent_q.size(), (sent_q.size() > 0) ? sent_q[0] : 8'hxx,
               (sent_q.size() > 1) ? sent_q[1] : 8'hxx);
    end
    checks++;
    if (dv_cycles != 2) begin
      errors++;
      $display("[TB] FAIL alu_dv_cycles: got %0d, required 2", dv_cycles);
    end
  endtask

  task automatic test_tie();
    bit ok;
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    exp_a = '{8'h11, 8'h33, 8'h22};
    exp_b = '{8'h33, 8'h22, 8'h11};
    sent_q.delete();
    pulse_both(8'h11, 16'h2233);
    checks++;
    if (bus.TXArb_RF_Pending !== 1'b1 || bus.TXArb_ALU_Pending !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tie_capture: rfp=%b alup=%b, required 1 1", bus.TXArb_RF_Pending, bus.TXArb_ALU_Pending);
    end
    wait_idle(ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sent_q.size() <= i || sent_q[i] !== exp_a[i]) begin
        errors++;
        $display("[TB] FAIL tie_rf_first[%0d]: got %h, required %h", i,
                 (sent_q.size() > i) ? sent_q[i] : 8'hxx, exp_a[i]);
      end
    end
    // A lone RF transfer makes RF the last grant, so the next tie goes to ALU
    pulse_rf(8'h44);
    wait_idle(ok);
    sent_q.delete();
    pulse_both(8'h11, 16'h2233);
    wait_idle(ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sent_q.size() <= i || sent_q[i] !== exp_b[i]) begin
        errors++;
        $display("[TB] FAIL tie_alu_first[%0d]: got %h, required %h", i,
                 (sent_q.size() > i) ? sent_q[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    sent_q.delete();
    model_en   = 1'b0;
    busy_force = 1'b1;
    pulse_rf(8'h01);
    pulse_rf(8'h02);
    checks++;
    if (bus.TXArb_Overrun !== 1'b1 || bus.TXArb_RF_Pending !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_pulse: ovr=%b rfp=%b, required 1 1", bus.TXArb_Overrun, bus.TXArb_RF_Pending);
    end
    tick();
    checks++;
    if (bus.TXArb_Overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_one_cycle: ovr=%b, required 0", bus.TXArb_Overrun);
    end
    busy_force = 1'b0;
    model_en   = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok || sent_q.size() != 1 || sent_q[0] !== 8'h01) begin
      errors++;
      $display("[TB] FAIL overrun_kept_old: count=%0d first=%h, required 1 and 01",
               sent_q.size(), (sent_q.size() > 0) ? sent_q[0] : 8'hxx);
    end
    sent_q.delete();
    model_en   = 1'b0;
    busy_force = 1'b1;
    pulse_rf(8'h03);
    busy_force         = 1'b0;
    model_en           = 1'b1;
    bus.TXArb_RF_Data  = 8'h04;
    bus.TXArb_RF_Valid = 1'b1;
    tick();
    bus.TXArb_RF_Valid = 1'b0;
    checks++;
    if (bus.TXArb_Overrun !== 1'b0 || bus.TXArb_RF_Pending !== 1'b1 ||
        bus.TXArb_Data_Valid !== 1'b1 || bus.TXArb_TXPdata_Out !== 8'h03) begin
      errors++;
      $display("[TB] FAIL grant_edge_capture: ovr=%b rfp=%b dv=%b txp=%h, required 0 1 1 03",
               bus.TXArb_Overrun, bus.TXArb_RF_Pending, bus.TXArb_Data_Valid, bus.TXArb_TXPdata_Out);
    end
    wait_idle(ok);
    checks++;
    if (!ok || sent_q.size() != 2 || sent_q[1] !== 8'h04) begin
      errors++;
      $display("[TB] FAIL grant_edge_second: count=%0d second=%h, required 2 and 04",
               sent_q.size(), (sent_q.size() > 1) ? sent_q[1] : 8'hxx);
    end
  endtask

  task automatic test_timeout();
    int dv_cnt = 0;
    int late_dv = 0;
    model_en   = 1'b0;
    busy_force = 1'b0;
    pulse_alu(16'hA5A5);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.TXArb_Data_Valid) dv_cnt++;
      else if (dv_cnt > 0) break;
    end
    checks++;
    if (dv_cnt != 8) begin
      errors++;
      $display("[TB] FAIL timeout_dv_width: dv high %0d cycles, required 8", dv_cnt);
    end
    checks++;
    if (bus.TXArb_Timeout !== 1'b1 || bus.TXArb_Idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: to=%b idle=%b, required 1 1", bus.TXArb_Timeout, bus.TXArb_Idle);
    end
    tick();
    checks++;
    if (bus.TXArb_Timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_one_cycle: to=%b, required 0", bus.TXArb_Timeout);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.TXArb_Data_Valid) late_dv++;
      tick();
    end
    checks++;
    if (late_dv != 0) begin
      errors++;
      $display("[TB] FAIL timeout_no_ms_byte: dv seen %0d cycles after abort, required 0", late_dv);
    end
  endtask

  task automatic test_busy_in_idle();
    bit ok;
    int early_dv = 0;
    sent_q.delete();
    model_en   = 1'b0;
    busy_force = 1'b1;
    pulse_rf(8'h77);
    for (int i = 0; i < 5; i++) begin
      if (bus.TXArb_Data_Valid) early_dv++;
      tick();
    end
    checks++;
    if (early_dv != 0 || bus.TXArb_RF_Pending !== 1'b1 || bus.TXArb_Idle !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_blocks_grant: dv_cycles=%0d rfp=%b idle=%b, required 0 1 0",
               early_dv, bus.TXArb_RF_Pending, bus.TXArb_Idle);
    end
    busy_force = 1'b0;
    model_en   = 1'b1;
    tick();
    checks++;
    if (bus.TXArb_Data_Valid !== 1'b1 || bus.TXArb_TXPdata_Out !== 8'h77 || bus.TXArb_RF_Pending !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_release_grant: dv=%b txp=%h rfp=%b, required 1 77 0",
               bus.TXArb_Data_Valid, bus.TXArb_TXPdata_Out, bus.TXArb_RF_Pending);
    end
    wait_idle(ok);
    checks++;
    if (!ok || sent_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL busy_release_done: idle=%b count=%0d, required 1 1", ok, sent_q.size());
    end
  endtask

  initial begin
    bus.TXArb_RF_Data   = '0;
    bus.TXArb_RF_Valid  = 1'b0;
    bus.TXArb_ALU_Out   = '0;
    bus.TXArb_ALU_Valid = 1'b0;
    test_reset();
    test_alu_16bit();
    test_tie();
    test_overrun();
    test_timeout();
    test_busy_in_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
